ucode_sequencer: RTL and testbench

- Microprogram sequencer for the ARC microarchitecture: owns the control store address register (CSAR) and drives the 11-bit address into the combinational microcode store.
- Each cycle it decodes the store's COND and JUMP ADDR fields, plus the PSR flags and IR, to select the next microaddress. Options are increment, conditional or unconditional jump, or DECODE dispatch.
- Stalls the microprogram while a main-memory read or write is pending. Faults on a memory timeout.

---
 rtl/ucode_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ucode_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microprogram sequencer for the ARC microarchitecture.
// Owns the control store address register (CSAR) and selects the next
// microaddress from the COND/JUMP fields, PSR flags and IR. The sequencer
// stalls while a memory access is pending and faults on a memory timeout.
// Optional feature macro: MICROSEQ_PERFCNT_EN adds retired/stall counters.
module ucode_sequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int MEM_TIMEOUT           = 255,
    parameter int DATAWIDTH_TIMEOUT     = 8
) (
    input  logic                             MICROSEQ_CLOCK_50,
    input  logic                             MICROSEQ_ResetInHigh_In,
    input  logic                             MICROSEQ_Enable_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICROSEQ_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQ_JumpAddress_InBus,
    input  logic                             MICROSEQ_RD_In,
    input  logic                             MICROSEQ_WR_In,
    input  logic                             MICROSEQ_MemReady_In,
    input  logic [3:0]                       MICROSEQ_PSR_InBus,
    input  logic [DATAWIDTH_IR-1:0]          MICROSEQ_IR_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQ_CSAddress_OutBus,
    output logic                             MICROSEQ_Step_Out,
    output logic                             MICROSEQ_Stall_Out,
`ifdef MICROSEQ_PERFCNT_EN
    output logic [15:0]                      MICROSEQ_RetiredCount_OutBus,
    output logic [15:0]                      MICROSEQ_StallCount_OutBus,
`endif
    output logic                             MICROSEQ_Fault_Out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [DATAWIDTH_TIMEOUT-1:0] TIMEOUT_LIMIT = DATAWIDTH_TIMEOUT'(MEM_TIMEOUT);

    state_t                             state;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   csar;
    logic [DATAWIDTH_TIMEOUT-1:0]       timeout_cnt;
    logic                               fault;
    logic                               access;
    logic                               step;
    logic                               stall;
    logic                               take_jump;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   next_addr;

    assign MICROSEQ_CSAddress_OutBus = csar;
    assign MICROSEQ_Fault_Out        = fault;
    assign MICROSEQ_Step_Out         = step;
    assign MICROSEQ_Stall_Out        = stall;

    // Retire/stall decode: a read and a write together count as one access.
    always_comb begin
        access = MICROSEQ_RD_In | MICROSEQ_WR_In;
        step   = 1'b0;
        stall  = 1'b0;
        case (state)
            ST_RUN: begin
                step  = MICROSEQ_Enable_In & (~access | MICROSEQ_MemReady_In);
                stall = MICROSEQ_Enable_In & access & ~MICROSEQ_MemReady_In;
            end
            ST_MEMWAIT: begin
                step  = MICROSEQ_MemReady_In;
                stall = 1'b1;
            end
            default: begin
                step  = 1'b0;
                stall = 1'b0;
            end
        endcase
    end

    // Next microaddress: increment, conditional/unconditional jump or DECODE dispatch.
    always_comb begin
        take_jump = 1'b0;
        case (MICROSEQ_Condition_InBus)
            3'b001:  take_jump = MICROSEQ_PSR_InBus[3];
            3'b010:  take_jump = MICROSEQ_PSR_InBus[2];
            3'b011:  take_jump = MICROSEQ_PSR_InBus[1];
            3'b100:  take_jump = MICROSEQ_PSR_InBus[0];
            3'b101:  take_jump = MICROSEQ_IR_InBus[13];
            3'b110:  take_jump = 1'b1;
            default: take_jump = 1'b0;
        endcase
        if (MICROSEQ_Condition_InBus == 3'b111) begin
            next_addr = DATAWIDTH_JUMPADDRESS'({1'b1, MICROSEQ_IR_InBus[31:30],
                                                MICROSEQ_IR_InBus[24:19], 2'b00});
        end else if (take_jump) begin
            next_addr = MICROSEQ_JumpAddress_InBus;
        end else begin
            // Natural wrap from the top of the store back to address 0.
            next_addr = csar + {{(DATAWIDTH_JUMPADDRESS-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer FSM: CSAR, memory-wait timeout counter and fault flag.
    always_ff @(posedge MICROSEQ_CLOCK_50 or posedge MICROSEQ_ResetInHigh_In) begin
        if (MICROSEQ_ResetInHigh_In) begin
            state       <= ST_IDLE;
            csar        <= '0;
            timeout_cnt <= '0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    csar <= '0;
                    if (MICROSEQ_Enable_In) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (MICROSEQ_Enable_In && access && !MICROSEQ_MemReady_In) begin
                        state       <= ST_MEMWAIT;
                        timeout_cnt <= {{(DATAWIDTH_TIMEOUT-1){1'b0}}, 1'b1};
                    end else if (step) begin
                        csar <= next_addr;
                    end
                end
                ST_MEMWAIT: begin
                    // Enable is deliberately ignored: the access must complete or time out.
                    if (MICROSEQ_MemReady_In) begin
                        csar        <= next_addr;
                        state       <= ST_RUN;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TIMEOUT_LIMIT) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + {{(DATAWIDTH_TIMEOUT-1){1'b0}}, 1'b1};
                    end
                end
                ST_FAULT: begin
                    // Terminal until reset; CSAR stays frozen for post-mortem.
                    fault <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    csar        <= '0;
                    timeout_cnt <= '0;
                    fault       <= 1'b0;
                end
            endcase
        end
    end

`ifdef MICROSEQ_PERFCNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;

    assign MICROSEQ_RetiredCount_OutBus = retired_cnt;
    assign MICROSEQ_StallCount_OutBus   = stall_cnt;

    // Performance counters: retired wraps, stall saturates.
    always_ff @(posedge MICROSEQ_CLOCK_50 or posedge MICROSEQ_ResetInHigh_In) begin
        if (MICROSEQ_ResetInHigh_In) begin
            retired_cnt <= 16'd0;
            stall_cnt   <= 16'd0;
        end else begin
            if (step) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer (built with MEM_TIMEOUT=4).
// Expected outputs are pushed to a scoreboard queue when a cycle's stimulus
// is driven and popped/compared when the DUT outputs are sampled.
module tb_ucode_sequencer;

    localparam int TMO = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_MW = 2, S_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd, wr, rdy;
    logic [3:0]  psr;
    logic [31:0] ir;
    logic [10:0] csa;
    logic        step, stall, fault;
`ifdef MICROSEQ_PERFCNT_EN
    logic [15:0] ret_cnt, stl_cnt;
`endif

    ucode_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .MICROSEQ_CLOCK_50          (clk),
        .MICROSEQ_ResetInHigh_In    (rst),
        .MICROSEQ_Enable_In         (en),
        .MICROSEQ_Condition_InBus   (cond),
        .MICROSEQ_JumpAddress_InBus (jump),
        .MICROSEQ_RD_In             (rd),
        .MICROSEQ_WR_In             (wr),
        .MICROSEQ_MemReady_In       (rdy),
        .MICROSEQ_PSR_InBus         (psr),
        .MICROSEQ_IR_InBus          (ir),
        .MICROSEQ_CSAddress_OutBus  (csa),
        .MICROSEQ_Step_Out          (step),
        .MICROSEQ_Stall_Out         (stall),
`ifdef MICROSEQ_PERFCNT_EN
        .MICROSEQ_RetiredCount_OutBus (ret_cnt),
        .MICROSEQ_StallCount_OutBus   (stl_cnt),
`endif
        .MICROSEQ_Fault_Out         (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] csar;
        logic        step;
        logic        stall;
        logic        fault;
        logic [15:0] ret;
        logic [15:0] stc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    // reference model state
    int          m_state;
    logic [10:0] m_csar;
    int          m_cnt;
    logic [15:0] m_ret, m_stc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] model_next(input logic [2:0] c, input logic [10:0] j,
                                               input logic [3:0] p, input logic [31:0] i,
                                               input logic [10:0] a);
        logic [10:0] r;
        case (c)
            3'd0: r = a + 11'd1;
            3'd1: r = p[3]  ? j : a + 11'd1;
            3'd2: r = p[2]  ? j : a + 11'd1;
            3'd3: r = p[1]  ? j : a + 11'd1;
            3'd4: r = p[0]  ? j : a + 11'd1;
            3'd5: r = i[13] ? j : a + 11'd1;
            3'd6: r = j;
            default: r = {1'b1, i[31:30], i[24:19], 2'b00};
        endcase
        return r;
    endfunction

    // Called at a negedge: asserts reset without any clock edge, checks, releases.
    task automatic do_reset();
        en  = 1'b0; rd = 1'b0; wr = 1'b0; rdy = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_csar",  {21'd0, csa}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_step",  {31'd0, step}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        m_state = S_IDLE; m_csar = 11'd0; m_cnt = 0; m_ret = 16'd0; m_stc = 16'd0;
        #3;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One clock: drive at negedge, push expectation, sample, advance model.
    task automatic cycle(input logic e, input logic [2:0] c, input logic [10:0] j,
                         input logic r, input logic w, input logic y,
                         input logic [3:0] p, input logic [31:0] i);
        exp_t ex, got;
        logic acc;
        en = e; cond = c; jump = j; rd = r; wr = w; rdy = y; psr = p; ir = i;
        acc = r | w;
        ex.csar  = m_csar;
        ex.fault = (m_state == S_FAULT);
        ex.ret   = m_ret;
        ex.stc   = m_stc;
        case (m_state)
            S_RUN:   begin ex.step = e & (~acc | y); ex.stall = e & acc & ~y; end
            S_MW:    begin ex.step = y;              ex.stall = 1'b1;         end
            default: begin ex.step = 1'b0;           ex.stall = 1'b0;         end
        endcase
        sb_q.push_back(ex);
        #2;
        got = sb_q.pop_front();
        check_eq("csar",  {21'd0, csa},   {21'd0, got.csar});
        check_eq("step",  {31'd0, step},  {31'd0, got.step});
        check_eq("stall", {31'd0, stall}, {31'd0, got.stall});
        check_eq("fault", {31'd0, fault}, {31'd0, got.fault});
`ifdef MICROSEQ_PERFCNT_EN
        check_eq("retired", {16'd0, ret_cnt}, {16'd0, got.ret});
        check_eq("stallcnt", {16'd0, stl_cnt}, {16'd0, got.stc});
`endif
        @(posedge clk);
        if (ex.step) m_ret = m_ret + 16'd1;
        if (ex.stall && m_stc != 16'hFFFF) m_stc = m_stc + 16'd1;
        case (m_state)
            S_IDLE: if (e) m_state = S_RUN;
            S_RUN: begin
                if (e && acc && !y) begin m_state = S_MW; m_cnt = 1; end
                else if (e) m_csar = model_next(c, j, p, i, m_csar);
            end
            S_MW: begin
                if (y) begin m_csar = model_next(c, j, p, i, m_csar); m_state = S_RUN; end
                else if (m_cnt == TMO) m_state = S_FAULT;
                else m_cnt++;
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic plain(input logic [2:0] c, input logic [10:0] j, input logic [3:0] p,
                         input logic [31:0] i);
        cycle(1'b1, c, j, 1'b0, 1'b0, 1'b0, p, i);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cond = 3'd0; jump = 11'd0; rd = 1'b0; wr = 1'b0;
        rdy = 1'b0; psr = 4'd0; ir = 32'd0;
        @(negedge clk);
        do_reset();

        // IDLE -> RUN, then sequential increment 0..3
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        for (int k = 0; k < 3; k++) plain(3'd0, 11'd0, 4'd0, 32'd0);
        check_eq("inc_to_3", {21'd0, csa}, 32'd3);

        // DECODE dispatch from CSAR=1
        plain(3'd6, 11'd1, 4'd0, 32'd0);
        plain(3'd7, 11'd0, 4'd0, 32'h8080_0000);
        check_eq("decode", {21'd0, csa}, 32'd1600);
        plain(3'd5, 11'd1602, 4'd0, 32'h0000_2000);
        check_eq("ir13_taken", {21'd0, csa}, 32'd1602);
        plain(3'd6, 11'd1600, 4'd0, 32'd0);
        plain(3'd5, 11'd1602, 4'd0, 32'd0);
        check_eq("ir13_not", {21'd0, csa}, 32'd1601);

        // flag branches
        plain(3'd2, 11'd1603, 4'b0100, 32'd0);
        check_eq("z_taken", {21'd0, csa}, 32'd1603);
        plain(3'd2, 11'd5, 4'b1011, 32'd0);
        check_eq("z_not", {21'd0, csa}, 32'd1604);
        plain(3'd1, 11'd7, 4'b1000, 32'd0);
        plain(3'd3, 11'd9, 4'b0010, 32'd0);
        plain(3'd4, 11'd100, 4'b1110, 32'd0);
        check_eq("c_not", {21'd0, csa}, 32'd10);

        // wrap-around at 2047
        plain(3'd6, 11'd2047, 4'd0, 32'd0);
        plain(3'd0, 11'd0, 4'b0000, 32'd0);
        check_eq("wrap", {21'd0, csa}, 32'd0);

        // read stall: ready on the third cycle
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle(1'b0, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        check_eq("mem_done", {21'd0, csa}, 32'd1);
        // RD and WR together with immediate ready, then enable low hold
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b1, 1'b1, 4'd0, 32'd0);
        cycle(1'b0, 3'd6, 11'd50, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        check_eq("en_hold", {21'd0, csa}, 32'd2);

        // randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            logic r, w, y;
            r = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 5) == 0);
            y = (r | w) ? ($urandom_range(0, 2) != 0) : $urandom_range(0, 1);
            cycle($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 11'($urandom),
                  r, w, y, 4'($urandom), $urandom);
            if (m_state == S_FAULT) do_reset();
        end

        // performance scenario: 10 steps, 3 stall cycles
        do_reset();
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        for (int k = 0; k < 9; k++) plain(3'd0, 11'd0, 4'd0, 32'd0);
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        check_eq("perf_csar", {21'd0, csa}, 32'd10);
`ifdef MICROSEQ_PERFCNT_EN
        check_eq("perf_retired", {16'd0, ret_cnt}, 32'd10);
        check_eq("perf_stalls",  {16'd0, stl_cnt}, 32'd3);
`endif

        // memory timeout -> FAULT, CSAR frozen at 2
        do_reset();
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        check_eq("tmo_fault", {31'd0, fault}, 32'd1);
        check_eq("tmo_csar",  {21'd0, csa}, 32'd2);
        cycle(1'b1, 3'd6, 11'd33, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
        cycle(1'b1, 3'd0, 11'd0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        check_eq("fault_frozen", {21'd0, csa}, 32'd2);
        do_reset();
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        plain(3'd0, 11'd0, 4'd0, 32'd0);
        check_eq("post_reset", {21'd0, csa}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
